// File: rtl/pf_pll_lock_ctrl.sv
// PLL power-up, lock qualification and recovery sequencer on the reference clock.
// Debounces LOCK, releases core reset after stable lock, power-cycles the PLL on timeout or loss.
module pf_pll_lock_ctrl #(
    parameter int unsigned PD_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lock,
    output logic       o_pll_powerdown_n,
    output logic       o_rst,
    output logic       o_ready,
    output logic       o_fail,
    output logic [3:0] o_retries,
    output logic [7:0] o_lost_cnt
);

    localparam int unsigned MAX_AB  = (PD_CYCLES > LOCK_TIMEOUT) ? PD_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PWRDN,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sync;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_retries_nxt;
    logic [7:0]       w_lost_nxt;
    logic             w_lock_s;

    assign w_lock_s = r_sync[1];

    // Next-state, counter and retry/loss bookkeeping; lock-low and lock-high take priority over count expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_retries_nxt = o_retries;
        w_lost_nxt    = o_lost_cnt;
        case (r_state)
            S_PWRDN: begin
                if (r_cnt == PD_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (o_retries == RETRY_LIMIT) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_retries_nxt = o_retries + 4'd1;
                        w_state_nxt   = S_PWRDN;
                    end
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_lost_nxt    = (o_lost_cnt != 8'hFF) ? o_lost_cnt + 8'd1 : o_lost_cnt;
                    w_retries_nxt = 4'd0;
                    w_state_nxt   = S_PWRDN;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_PWRDN;
            end
        endcase

        // Count only while residing in a timed state; RUN and FAIL park the counter at zero.
        if ((w_state_nxt == r_state) &&
            ((r_state == S_PWRDN) || (r_state == S_WAIT_LOCK) || (r_state == S_STABLE))) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State, synchronizer and outputs, all registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= S_PWRDN;
            r_cnt             <= '0;
            r_sync            <= 2'b00;
            o_pll_powerdown_n <= 1'b0;
            o_rst             <= 1'b1;
            o_ready           <= 1'b0;
            o_fail            <= 1'b0;
            o_retries         <= 4'd0;
            o_lost_cnt        <= 8'd0;
        end else begin
            r_sync            <= {r_sync[0], i_lock};
            r_state           <= w_state_nxt;
            r_cnt             <= w_cnt_nxt;
            o_pll_powerdown_n <= (w_state_nxt == S_WAIT_LOCK) || (w_state_nxt == S_STABLE) ||
                                 (w_state_nxt == S_RUN);
            o_rst             <= (w_state_nxt != S_RUN);
            o_ready           <= (w_state_nxt == S_RUN);
            o_fail            <= (w_state_nxt == S_FAIL);
            o_retries         <= w_retries_nxt;
            o_lost_cnt        <= w_lost_nxt;
        end
    end

endmodule
